// File: rtl/down_counter16_pkg.sv
// ----------------------------------------------------------------------------
// down_counter16_pkg : shared word width and FSM state encodings
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package down_counter16_pkg;

  localparam int WORD_WIDTH = 16;

  // 2'd3 is unused and recovers to IDLE in the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/down_counter16_dec16_gate.sv
// ----------------------------------------------------------------------------
// dec16_gate : combinational 16-bit decrementer, out = in - 1 modulo 2^16
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module dec16_gate
  import down_counter16_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] in,
  output logic [WORD_WIDTH-1:0] out
);

  // Ripple-borrow chain: subtracting one flips bits up to and including the lowest set bit.
  logic [WORD_WIDTH-1:0] borrow;

  assign borrow[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WORD_WIDTH; i++) begin : g_bit
      assign out[i] = in[i] ^ borrow[i];
      if (i < WORD_WIDTH - 1) begin : g_borrow
        assign borrow[i+1] = ~in[i] & borrow[i];
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/down_counter16.sv
// ----------------------------------------------------------------------------
// down_counter16 : loadable 16-bit down-counter/timer with prescaler and FSM
// Optional macro DOWN_COUNTER16_AUTO_RELOAD_EN: reload last load value at terminal count
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module down_counter16
  import down_counter16_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [WORD_WIDTH-1:0] load_value,
  output logic                  load_ready,
  input  logic                  en,
  input  logic                  abort,
  input  logic                  ack,
  output logic [WORD_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done_pulse,
  output logic                  expired
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  generate
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $error("down_counter16: PRESCALE must be in 1..256");
    end
  endgenerate

  state_t                state, state_next;
  logic [WORD_WIDTH-1:0] count_next;
  logic [WORD_WIDTH-1:0] count_dec;
  logic [PS_W-1:0]       ps, ps_next;
  logic                  done_next;
  logic                  load_accept;

`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
  logic [WORD_WIDTH-1:0] last_load, last_load_next;
`endif

  dec16_gate u_dec (
    .in  (count),
    .out (count_dec)
  );

  assign busy        = (state == ST_RUN);
  assign expired     = (state == ST_DONE);
  assign load_ready  = (state != ST_RUN);
  assign load_accept = load_valid && load_ready;

  always_comb begin
    state_next = state;
    count_next = count;
    ps_next    = ps;
    done_next  = 1'b0;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
    last_load_next = last_load;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        if (load_accept) begin
          count_next = load_value;
          ps_next    = '0;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
          last_load_next = load_value;
`endif
          if (load_value == '0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end else if (state == ST_DONE && ack) begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort outranks the terminal decrement in the same cycle.
        if (abort) begin
          state_next = ST_IDLE;
          ps_next    = '0;
        end else if (en) begin
          if (ps == PS_MAX) begin
            ps_next = '0;
            if (count == WORD_WIDTH'(1)) begin
              done_next = 1'b1;
`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
              count_next = last_load;
`else
              count_next = count_dec;
              state_next = ST_DONE;
`endif
            end else begin
              count_next = count_dec;
            end
          end else begin
            ps_next = ps + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      ps         <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      ps         <= ps_next;
      done_pulse <= done_next;
    end
  end

`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_load <= '0;
    end else begin
      last_load <= last_load_next;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_down_counter16.sv
// ----------------------------------------------------------------------------
// tb_down_counter16 : directed self-checking bench for down_counter16 (PRESCALE 1 and 4)
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_down_counter16;

`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        lv1 = 1'b0, en1 = 1'b0, ab1 = 1'b0, ack1 = 1'b0;
  logic [15:0] val1 = '0;
  logic        rdy1, busy1, dp1, exp1;
  logic [15:0] cnt1;

  logic        lv4 = 1'b0, en4 = 1'b0, ab4 = 1'b0, ack4 = 1'b0;
  logic [15:0] val4 = '0;
  logic        rdy4, busy4, dp4, exp4;
  logic [15:0] cnt4;

  int n_checks = 0;
  int n_fail = 0;

  down_counter16 #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_value(val1), .load_ready(rdy1),
    .en(en1), .abort(ab1), .ack(ack1), .count(cnt1), .busy(busy1),
    .done_pulse(dp1), .expired(exp1)
  );

  down_counter16 #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv4), .load_value(val4), .load_ready(rdy4),
    .en(en4), .abort(ab4), .ack(ack4), .count(cnt4), .busy(busy4),
    .done_pulse(dp4), .expired(exp4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---- reset state
    tick();
    tick();
    chk("rst count", cnt1, 16'h0);
    chk("rst busy", 16'(busy1), 16'd0);
    chk("rst expired", 16'(exp1), 16'd0);
    chk("rst done_pulse", 16'(dp1), 16'd0);
    chk("rst load_ready", 16'(rdy1), 16'd1);
    rst_n = 1'b1;
    tick();

    // ---- PRESCALE=1, load 3: 3,2,1,0
    lv1 = 1'b1; val1 = 16'd3; en1 = 1'b1;
    tick();
    lv1 = 1'b0;
    chk("p1 load count", cnt1, 16'd3);
    chk("p1 load busy", 16'(busy1), 16'd1);
    chk("p1 load ready", 16'(rdy1), 16'd0);
    chk("p1 load dp", 16'(dp1), 16'd0);
    tick();
    chk("p1 count2", cnt1, 16'd2);
    tick();
    chk("p1 count1", cnt1, 16'd1);
    chk("p1 dp before", 16'(dp1), 16'd0);
    tick();
    chk("p1 terminal count", cnt1, AR ? 16'd3 : 16'd0);
    chk("p1 terminal dp", 16'(dp1), 16'd1);
    chk("p1 terminal expired", 16'(exp1), AR ? 16'd0 : 16'd1);
    chk("p1 terminal ready", 16'(rdy1), AR ? 16'd0 : 16'd1);
    // ack clears DONE; abort clears RUN when reloading
    ack1 = 1'b1; ab1 = 1'b1;
    tick();
    ack1 = 1'b0; ab1 = 1'b0;
    chk("p1 idle busy", 16'(busy1), 16'd0);
    chk("p1 idle expired", 16'(exp1), 16'd0);
    chk("p1 idle dp", 16'(dp1), 16'd0);

    // ---- abort at count 3
    lv1 = 1'b1; val1 = 16'd5;
    tick();
    lv1 = 1'b0;
    chk("ab load", cnt1, 16'd5);
    tick();
    tick();
    chk("ab count3", cnt1, 16'd3);
    ab1 = 1'b1;
    tick();
    ab1 = 1'b0;
    chk("ab hold count", cnt1, 16'd3);
    chk("ab busy", 16'(busy1), 16'd0);
    chk("ab dp", 16'(dp1), 16'd0);
    tick();
    chk("ab idle hold", cnt1, 16'd3);

    // ---- abort coincident with the 1->0 decrement
    lv1 = 1'b1; val1 = 16'd2;
    tick();
    lv1 = 1'b0;
    tick();
    chk("ab1 count1", cnt1, 16'd1);
    ab1 = 1'b1;
    tick();
    ab1 = 1'b0;
    chk("ab1 hold count", cnt1, 16'd1);
    chk("ab1 dp", 16'(dp1), 16'd0);
    chk("ab1 expired", 16'(exp1), 16'd0);
    chk("ab1 busy", 16'(busy1), 16'd0);

    // ---- load 0 -> DONE, then load beats ack
    lv1 = 1'b1; val1 = 16'd0;
    tick();
    chk("z expired", 16'(exp1), 16'd1);
    chk("z dp", 16'(dp1), 16'd1);
    chk("z count", cnt1, 16'd0);
    chk("z busy", 16'(busy1), 16'd0);
    val1 = 16'hFFFF; ack1 = 1'b1;
    tick();
    lv1 = 1'b0; ack1 = 1'b0;
    chk("z2 busy", 16'(busy1), 16'd1);
    chk("z2 count", cnt1, 16'hFFFF);
    chk("z2 dp", 16'(dp1), 16'd0);
    chk("z2 expired", 16'(exp1), 16'd0);
    tick();
    chk("z2 dec", cnt1, 16'hFFFE);

    // ---- load ignored in RUN, en=0 holds
    lv1 = 1'b1; val1 = 16'd7; en1 = 1'b0;
    tick();
    lv1 = 1'b0;
    chk("run ignore load", cnt1, 16'hFFFE);
    chk("run ready", 16'(rdy1), 16'd0);
    tick();
    chk("en0 hold", cnt1, 16'hFFFE);
    ab1 = 1'b1;
    tick();
    ab1 = 1'b0;

    // ---- PRESCALE=4, load 2, en steady: done 8 cycles after load edge
    lv4 = 1'b1; val4 = 16'd2; en4 = 1'b1;
    tick();
    lv4 = 1'b0;
    chk("p4 load", cnt4, 16'd2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("p4 count k%0d", k), cnt4,
          (k < 4) ? 16'd2 : (k < 8) ? 16'd1 : (AR ? 16'd2 : 16'd0));
      chk($sformatf("p4 dp k%0d", k), 16'(dp4), (k == 8) ? 16'd1 : 16'd0);
    end
    chk("p4 expired", 16'(exp4), AR ? 16'd0 : 16'd1);
    ack4 = 1'b1; ab4 = 1'b1;
    tick();
    ack4 = 1'b0; ab4 = 1'b0;

    // ---- PRESCALE=4 with en low on edges 3 and 4: done stretched to edge 10
    lv4 = 1'b1; val4 = 16'd2;
    tick();
    lv4 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      en4 = (k != 3 && k != 4);
      tick();
      chk($sformatf("p4en count k%0d", k), cnt4,
          (k < 6) ? 16'd2 : (k < 10) ? 16'd1 : (AR ? 16'd2 : 16'd0));
      chk($sformatf("p4en dp k%0d", k), 16'(dp4), (k == 10) ? 16'd1 : 16'd0);
    end
    en4 = 1'b0;

`ifdef DOWN_COUNTER16_AUTO_RELOAD_EN
    // ---- auto-reload: 2,1,2,1,2 with pulse on each reload
    lv1 = 1'b1; val1 = 16'd2; en1 = 1'b1;
    tick();
    lv1 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      chk($sformatf("ar count k%0d", k), cnt1, (k % 2 == 0) ? 16'd2 : 16'd1);
      chk($sformatf("ar dp k%0d", k), 16'(dp1), (k == 2 || k == 4) ? 16'd1 : 16'd0);
      chk($sformatf("ar expired k%0d", k), 16'(exp1), 16'd0);
    end
    en1 = 1'b0; ab1 = 1'b1;
    tick();
    ab1 = 1'b0;
`endif

    // ---- asynchronous reset mid-RUN at 0x1234
    lv1 = 1'b1; val1 = 16'h1234; en1 = 1'b0;
    tick();
    lv1 = 1'b0;
    chk("ar1234 count", cnt1, 16'h1234);
    chk("ar1234 busy", 16'(busy1), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async count", cnt1, 16'h0);
    chk("async busy", 16'(busy1), 16'd0);
    chk("async expired", 16'(exp1), 16'd0);
    chk("async ready", 16'(rdy1), 16'd1);
    chk("async dp", 16'(dp1), 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post rst count", cnt1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
